// File: rtl/lpf_pixel_source.sv
// Horizontal 1-2-1 low-pass filter with edge replication feeding a small output FIFO.
// Define LPF_BYPASS_EN to add a bypass input that pushes raw pixels instead of filtered ones.
module lpf_pixel_source #(
    parameter int LINE_WIDTH = 640,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_flag,
    input  logic [17:0]        in_pixel,
    input  logic               in_flag,
    input  logic               request_pixel,
`ifdef LPF_BYPASS_EN
    input  logic               bypass,
`endif
    output logic [17:0]        pixel,
    output logic               pixel_flag,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [XW-1:0]    X_LAST = XW'(LINE_WIDTH - 1);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_EDGE = 2'd2;

    logic [17:0]        prev_r;
    logic [17:0]        cur_r;
    logic [XW-1:0]      x_r;
    logic [1:0]         state_r;
    logic               push_r;
    logic [17:0]        push_data_r;
    logic [17:0]        mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;

    logic               bypass_s;
    logic [XW-1:0]      eff_x_s;
    logic [1:0]         eff_state_s;
    logic               pop_s;
    logic               full_s;
    logic               wr_en_s;

    // Per-component (a + 2b + c + 2) >> 2; the 8-bit sum peaks at 254, so no component carries.
    function automatic logic [17:0] filt(input logic [17:0] a, input logic [17:0] b,
                                         input logic [17:0] c);
        logic [7:0]  sum;
        logic [17:0] res;
        res = 18'd0;
        for (int k = 0; k < 3; k++) begin
            sum = {2'b00, a[k*6 +: 6]} + {1'b0, b[k*6 +: 6], 1'b0} + {2'b00, c[k*6 +: 6]} + 8'd2;
            res[k*6 +: 6] = sum[7:2];
        end
        return res;
    endfunction

`ifdef LPF_BYPASS_EN
    assign bypass_s = bypass;
`else
    assign bypass_s = 1'b0;
`endif

    // A frame pulse makes this cycle look like the start of a fresh line.
    always_comb begin
        eff_x_s     = x_r;
        eff_state_s = state_r;
        if (frame_flag) begin
            eff_x_s     = {XW{1'b0}};
            eff_state_s = ST_IDLE;
        end else begin
            eff_x_s     = x_r;
            eff_state_s = state_r;
        end
    end

    // FIFO status; a write while full is accepted only if a pop frees a slot in the same cycle.
    always_comb begin
        pop_s   = request_pixel && (fifo_count != {(FIFO_AW + 1){1'b0}});
        full_s  = (fifo_count == FULL_COUNT);
        wr_en_s = push_r && (!full_s || pop_s);
    end

    // Line pipeline: tracks x, shifts prev/cur and stages one push for the following cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_r      <= 18'd0;
            cur_r       <= 18'd0;
            x_r         <= {XW{1'b0}};
            state_r     <= ST_IDLE;
            push_r      <= 1'b0;
            push_data_r <= 18'd0;
        end else begin
            push_r <= 1'b0;
            if (in_flag && bypass_s) begin
                push_r      <= 1'b1;
                push_data_r <= in_pixel;
                x_r         <= (eff_x_s == X_LAST) ? {XW{1'b0}} : eff_x_s + XW'(1);
                state_r     <= ST_IDLE;
            end else if (in_flag && (eff_x_s == {XW{1'b0}})) begin
                prev_r  <= in_pixel;
                cur_r   <= in_pixel;
                x_r     <= XW'(1);
                state_r <= ST_RUN;
            end else if (in_flag) begin
                push_r      <= 1'b1;
                push_data_r <= filt(prev_r, cur_r, in_pixel);
                prev_r      <= cur_r;
                cur_r       <= in_pixel;
                if (eff_x_s == X_LAST) begin
                    x_r     <= {XW{1'b0}};
                    state_r <= ST_EDGE;
                end else begin
                    x_r     <= eff_x_s + XW'(1);
                    state_r <= ST_RUN;
                end
            end else if (eff_state_s == ST_EDGE) begin
                // prev/cur already shifted, so this is filt(old cur, last, last).
                push_r      <= 1'b1;
                push_data_r <= filt(prev_r, cur_r, cur_r);
                state_r     <= ST_IDLE;
            end else if (frame_flag) begin
                prev_r  <= 18'd0;
                cur_r   <= 18'd0;
                x_r     <= {XW{1'b0}};
                state_r <= ST_IDLE;
            end else begin
                state_r <= state_r;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the registered output handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r   <= {FIFO_AW{1'b0}};
            rd_ptr_r   <= {FIFO_AW{1'b0}};
            fifo_count <= {(FIFO_AW + 1){1'b0}};
            pixel      <= 18'd0;
            pixel_flag <= 1'b0;
            overflow   <= 1'b0;
        end else if (frame_flag) begin
            wr_ptr_r   <= {FIFO_AW{1'b0}};
            rd_ptr_r   <= {FIFO_AW{1'b0}};
            fifo_count <= {(FIFO_AW + 1){1'b0}};
            pixel_flag <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                pixel      <= mem_r[rd_ptr_r];
                pixel_flag <= 1'b1;
                rd_ptr_r   <= rd_ptr_r + FIFO_AW'(1);
            end else begin
                pixel_flag <= 1'b0;
            end
            fifo_count <= fifo_count + {{FIFO_AW{1'b0}}, wr_en_s} - {{FIFO_AW{1'b0}}, pop_s};
            if (push_r && full_s && !pop_s) begin
                overflow <= 1'b1;
            end else begin
                overflow <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_lpf_pixel_source.sv
// Self-checking bench for lpf_pixel_source: a line-level reference model (edge-replicated
// 1-2-1 filter, 16-entry capacity) is compared against the popped pixel stream.
module tb_lpf_pixel_source;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_flag = 1'b0;
    logic [17:0] in_pixel = 18'd0;
    logic        in_flag = 1'b0;
    logic        request_pixel = 1'b0;
    logic [17:0] pixel;
    logic        pixel_flag;
    logic [4:0]  fifo_count;
    logic        overflow;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] got [$];
    logic [17:0] exp_q [$];
    logic        model_ovf = 1'b0;

    lpf_pixel_source #(.LINE_WIDTH(LW), .FIFO_AW(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_flag    (frame_flag),
        .in_pixel      (in_pixel),
        .in_flag       (in_flag),
        .request_pixel (request_pixel),
`ifdef LPF_BYPASS_EN
        .bypass        (1'b0),
`endif
        .pixel         (pixel),
        .pixel_flag    (pixel_flag),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (pixel_flag === 1'b1) got.push_back(pixel);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [17:0] filt_ref(input logic [17:0] a, input logic [17:0] b,
                                             input logic [17:0] c);
        logic [17:0] r;
        int s;
        r = 18'd0;
        for (int k = 0; k < 3; k++) begin
            s = int'(a[k*6 +: 6]) + 2 * int'(b[k*6 +: 6]) + int'(c[k*6 +: 6]) + 2;
            r[k*6 +: 6] = 6'(s / 4);
        end
        return r;
    endfunction

    // Expected outputs of one whole line, kept only while the modelled FIFO has room.
    task automatic model_line(input logic [17:0] p [LW]);
        logic [17:0] l, r, v;
        for (int i = 0; i < LW; i++) begin
            l = (i == 0) ? p[0] : p[i-1];
            r = (i == LW - 1) ? p[LW-1] : p[i+1];
            v = filt_ref(l, p[i], r);
            if (exp_q.size() < 16) exp_q.push_back(v);
            else model_ovf = 1'b1;
        end
    endtask

    task automatic send_line(input logic [17:0] p [LW]);
        for (int i = 0; i < LW; i++) begin
            in_pixel = p[i];
            in_flag  = 1'b1;
            tick();
            in_flag  = 1'b0;
            tick();
        end
        model_line(p);
    endtask

    task automatic random_line(output logic [17:0] p [LW]);
        for (int i = 0; i < LW; i++) p[i] = 18'($urandom);
    endtask

    task automatic clear_frame();
        frame_flag = 1'b1;
        tick();
        frame_flag = 1'b0;
        tick();
        got.delete();
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_pixel = 18'($urandom);
        in_flag  = 1'b1;
        tick();
        in_flag  = 1'b0;
        tick();
        n_cmp++; if (pixel !== 18'd0) begin n_err++; $display("FAIL reset_pixel actual=%h required=%h", pixel, 18'd0); end
        n_cmp++; if (pixel_flag !== 1'b0) begin n_err++; $display("FAIL reset_flag actual=%b required=0", pixel_flag); end
        n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL reset_count actual=%0d required=0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow actual=%b required=0", overflow); end
        reset_n = 1'b1;
        request_pixel = 1'b1;
        repeat (4) tick();
        n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL reset_no_pop actual=%0d required=0", got.size()); end
        got.delete();
    endtask

    task automatic test_flat_line();
        logic [17:0] p [LW];
        got.delete();
        request_pixel = 1'b1;
        for (int i = 0; i < LW; i++) p[i] = 18'h0AAAA;
        for (int i = 0; i < LW - 1; i++) begin
            in_pixel = p[i]; in_flag = 1'b1; tick(); in_flag = 1'b0; tick();
        end
        in_pixel = p[LW-1]; in_flag = 1'b1; tick(); in_flag = 1'b0;
        tick();
        n_cmp++; if (pixel_flag !== 1'b0) begin n_err++; $display("FAIL flat_c1_flag actual=%b required=0", pixel_flag); end
        tick();
        n_cmp++; if (pixel_flag !== 1'b1 || pixel !== 18'h0AAAA) begin n_err++; $display("FAIL flat_c2 actual=%b/%h required=1/0aaaa", pixel_flag, pixel); end
        tick();
        n_cmp++; if (pixel_flag !== 1'b1 || pixel !== 18'h0AAAA) begin n_err++; $display("FAIL flat_c3_last actual=%b/%h required=1/0aaaa", pixel_flag, pixel); end
        tick();
        n_cmp++; if (pixel_flag !== 1'b0) begin n_err++; $display("FAIL flat_c4_flag actual=%b required=0", pixel_flag); end
        n_cmp++; if (got.size() !== LW) begin n_err++; $display("FAIL flat_count actual=%0d required=%0d", got.size(), LW); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++; if (got[i] !== 18'h0AAAA) begin n_err++; $display("FAIL flat_pix%0d actual=%h required=0aaaa", i, got[i]); end
        end
        got.delete();
    endtask

    task automatic test_rounding();
        logic [17:0] p [LW];
        logic [5:0]  want [LW];
        want[0] = 6'd16; want[1] = 6'd32; want[2] = 6'd32; want[3] = 6'd47;
        p[0] = 18'd0; p[1] = 18'd63; p[2] = 18'd0; p[3] = 18'd63;
        got.delete();
        request_pixel = 1'b1;
        send_line(p);
        repeat (4) tick();
        n_cmp++; if (got.size() !== LW) begin n_err++; $display("FAIL round_count actual=%0d required=%0d", got.size(), LW); end
        for (int i = 0; i < LW && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== {12'd0, want[i]}) begin n_err++; $display("FAIL round_pix%0d actual=%h required=%h", i, got[i], {12'd0, want[i]}); end
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic test_random_lines();
        logic [17:0] p [LW];
        request_pixel = 1'b1;
        for (int r = 0; r < 4; r++) begin
            got.delete();
            exp_q.delete();
            random_line(p);
            send_line(p);
            repeat (4) tick();
            n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL rand%0d_count actual=%0d required=%0d", r, got.size(), exp_q.size()); end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_pix%0d actual=%h required=%h", r, i, got[i], exp_q[i]); end
            end
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [17:0] p [LW];
        request_pixel = 1'b0;
        clear_frame();
        for (int l = 0; l < 5; l++) begin
            random_line(p);
            send_line(p);
        end
        repeat (4) tick();
        n_cmp++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL bp_count actual=%0d required=16", fifo_count); end
        n_cmp++; if (overflow !== model_ovf) begin n_err++; $display("FAIL bp_overflow actual=%b required=%b", overflow, model_ovf); end
        request_pixel = 1'b1;
        repeat (20) tick();
        n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_popped actual=%0d required=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_pix%0d actual=%h required=%h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL bp_drained actual=%0d required=0", fifo_count); end
    endtask

    task automatic test_frame_mid_line();
        logic [17:0] p [LW];
        request_pixel = 1'b0;
        clear_frame();
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL frame_ovf_clear actual=%b required=0", overflow); end
        for (int i = 0; i < 2; i++) begin
            in_pixel = 18'($urandom); in_flag = 1'b1; tick(); in_flag = 1'b0; tick();
        end
        in_pixel = 18'($urandom); in_flag = 1'b1; tick(); in_flag = 1'b0;
        frame_flag = 1'b1; tick(); frame_flag = 1'b0;
        tick();
        n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL frame_count actual=%0d required=0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL frame_overflow actual=%b required=0", overflow); end
        request_pixel = 1'b1;
        got.delete();
        exp_q.delete();
        random_line(p);
        send_line(p);
        repeat (4) tick();
        n_cmp++; if (got.size() !== LW) begin n_err++; $display("FAIL frame_newline_count actual=%0d required=%0d", got.size(), LW); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL frame_pix%0d actual=%h required=%h", i, got[i], exp_q[i]); end
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic test_concurrent();
        logic [17:0] p [LW];
        logic [17:0] head;
        request_pixel = 1'b0;
        clear_frame();
        for (int l = 0; l < 4; l++) begin
            random_line(p);
            send_line(p);
        end
        repeat (4) tick();
        n_cmp++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL conc_fill actual=%0d required=16", fifo_count); end
        head = exp_q[0];
        in_pixel = 18'($urandom); in_flag = 1'b1; tick(); in_flag = 1'b0; tick();
        in_pixel = 18'($urandom); in_flag = 1'b1; tick(); in_flag = 1'b0;
        request_pixel = 1'b1;
        tick();
        request_pixel = 1'b0;
        n_cmp++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL conc_count actual=%0d required=16", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL conc_overflow actual=%b required=0", overflow); end
        n_cmp++; if (pixel_flag !== 1'b1 || pixel !== head) begin n_err++; $display("FAIL conc_pop actual=%b/%h required=1/%h", pixel_flag, pixel, head); end
        tick();
        n_cmp++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL conc_hold actual=%0d required=16", fifo_count); end
        clear_frame();
    endtask

    initial begin
        test_reset();
        test_flat_line();
        test_rounding();
        test_random_lines();
        test_backpressure();
        test_frame_mid_line();
        test_concurrent();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
